single_conv_loader: RTL

SINGLE_CONV_LOADER -- requirements
Module: single_conv_loader

---
 rtl/single_conv_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/single_conv_loader.sv
// Streams a 4x4 activation matrix and a 3x3 filter into registers, then runs the
// convolution block and latches its 2x2 result. A watchdog bounds the run time.
module single_conv_loader #(
    parameter int WDOG_LIMIT = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] a11, a12, a13, a14,
    output logic [7:0] a21, a22, a23, a24,
    output logic [7:0] a31, a32, a33, a34,
    output logic [7:0] a41, a42, a43, a44,
    output logic [7:0] b11, b12, b13,
    output logic [7:0] b21, b22, b23,
    output logic [7:0] b31, b32, b33,
    output logic       active_single,
    input  logic       done_single,
    input  logic [7:0] c11_in, c12_in, c21_in, c22_in,
    output logic [7:0] res_c11, res_c12, res_c21, res_c22,
    output logic       res_valid,
    output logic       err
);

    // state  | meaning
    // LOAD_A | accepting activation bytes, cnt 0..15
    // LOAD_B | accepting filter bytes, cnt 16..24
    // RUN    | convolution running, watchdog counting
    // DONE   | one-cycle result-valid slot
    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [5:0] WD_LAST = 6'(WDOG_LIMIT - 1);

    logic [1:0] state;
    logic [4:0] cnt;
    logic [5:0] wd;
    logic [7:0] a_mem [16];
    logic [7:0] b_mem [9];
    logic       accept;
    logic [4:0] b_idx;
    logic       wd_expire;

    assign in_ready  = ((state == LOAD_A) || (state == LOAD_B)) && !flush;
    assign accept    = in_valid && in_ready;
    assign b_idx     = cnt - 5'd16;
    assign wd_expire = (wd == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= LOAD_A;
            cnt           <= 5'd0;
            wd            <= 6'd0;
            active_single <= 1'b0;
            res_valid     <= 1'b0;
            err           <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (flush) begin
                        cnt <= 5'd0;
                    end else if (accept) begin
                        if (cnt == 5'd15) state <= LOAD_B;
                        cnt <= cnt + 5'd1;
                    end
                end
                LOAD_B: begin
                    if (flush) begin
                        cnt   <= 5'd0;
                        state <= LOAD_A;
                    end else if (accept) begin
                        if (cnt == 5'd24) begin
                            state         <= RUN;
                            cnt           <= 5'd0;
                            wd            <= 6'd0;
                            active_single <= 1'b1;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                RUN: begin
                    // completion wins over a timeout landing on the same cycle
                    if (done_single) begin
                        state         <= DONE;
                        active_single <= 1'b0;
                        res_valid     <= 1'b1;
                    end else if (wd_expire) begin
                        err           <= 1'b1;
                        state         <= LOAD_A;
                        active_single <= 1'b0;
                    end else begin
                        wd <= wd + 6'd1;
                    end
                end
                DONE: begin
                    state <= LOAD_A;
                    cnt   <= 5'd0;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) a_mem[i] <= 8'd0;
            for (int i = 0; i < 9; i++)  b_mem[i] <= 8'd0;
        end else if (accept) begin
            if (state == LOAD_A) begin
                a_mem[cnt[3:0]] <= in_data;
            end else if ((state == LOAD_B) && (b_idx < 5'd9)) begin
                b_mem[b_idx[3:0]] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_c11 <= 8'd0;
            res_c12 <= 8'd0;
            res_c21 <= 8'd0;
            res_c22 <= 8'd0;
        end else if ((state == RUN) && done_single) begin
            res_c11 <= c11_in;
            res_c12 <= c12_in;
            res_c21 <= c21_in;
            res_c22 <= c22_in;
        end
    end

    assign a11 = a_mem[0];
    assign a12 = a_mem[1];
    assign a13 = a_mem[2];
    assign a14 = a_mem[3];
    assign a21 = a_mem[4];
    assign a22 = a_mem[5];
    assign a23 = a_mem[6];
    assign a24 = a_mem[7];
    assign a31 = a_mem[8];
    assign a32 = a_mem[9];
    assign a33 = a_mem[10];
    assign a34 = a_mem[11];
    assign a41 = a_mem[12];
    assign a42 = a_mem[13];
    assign a43 = a_mem[14];
    assign a44 = a_mem[15];

    assign b11 = b_mem[0];
    assign b12 = b_mem[1];
    assign b13 = b_mem[2];
    assign b21 = b_mem[3];
    assign b22 = b_mem[4];
    assign b23 = b_mem[5];
    assign b31 = b_mem[6];
    assign b32 = b_mem[7];
    assign b33 = b_mem[8];

endmodule
